// File: rtl/ml_peak_det.sv
`timescale 1ns/1ps
// Peak detector for ML timing metrics: finds the first maximum in a window of
// WIN_LEN accepted samples and reports {found, peak_idx, peak_val} against a threshold.
module ml_peak_det #(
    parameter int WIDTH   = 17,
    parameter int WIN_LEN = 64,
    parameter int IDX_W   = 6
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic                   CYC_I,
    input  logic                   STB_I,
    input  logic [WIDTH-1:0]       DAT_I,
    input  logic [WIDTH-1:0]       THR_I,
    output logic                   ACK_O,
    output logic                   STB_O,
    output logic [IDX_W+WIDTH:0]   DAT_O,
    input  logic                   ACK_I
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       count_q, count_d;
    logic [WIDTH-1:0]       max_q, max_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WIDTH-1:0]       thr_q, thr_d;
    logic [IDX_W+WIDTH:0]   res_q, res_d;

    logic [WIDTH-1:0]       cand_max;
    logic [IDX_W-1:0]       cand_idx;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        max_d    = max_q;
        idx_d    = idx_q;
        thr_d    = thr_q;
        res_d    = res_q;
        ACK_O    = 1'b0;
        STB_O    = 1'b0;
        cand_max = max_q;
        cand_idx = idx_q;

        // Strictly-greater update keeps the earliest index on ties.
        if (DAT_I > max_q) begin
            cand_max = DAT_I;
            cand_idx = count_q;
        end

        case (state_q)
            IDLE: begin
                if (CYC_I) begin
                    state_d = SEARCH;
                    count_d = '0;
                    max_d   = '0;
                    idx_d   = '0;
                    thr_d   = THR_I;
                end
            end
            SEARCH: begin
                ACK_O = STB_I & CYC_I;
                if (!CYC_I) begin
                    state_d = IDLE;
                end else if (STB_I) begin
                    max_d   = cand_max;
                    idx_d   = cand_idx;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_IDX) begin
                        state_d = REPORT;
                        res_d   = {(cand_max >= thr_q), cand_idx, cand_max};
                    end
                end
            end
            REPORT: begin
                STB_O = 1'b1;
                if (ACK_I) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            count_q <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            thr_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            thr_q   <= thr_d;
            res_q   <= res_d;
        end
    end

    assign DAT_O = res_q;

endmodule
